// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
//
// Turns a debounced key level into discrete key events held in a single-entry
// output register with valid/ready handshake.
//
//   PRESS (1)         key goes down
//   SHORT_RELEASE (2) key released before the long-press threshold
//   LONG (3)          key held for LONG_CYCLES since PRESS
//   REPEAT (4)        every REPEAT_CYCLES while in long-press
//   LONG_RELEASE (5)  key released after LONG
//
// Build option:
//   KEY_EVENT_REPEAT_EN  defined   -> REPEAT events are generated in long-press
//                        undefined -> no repeat counter, code 4 never appears
//
// Parameters:
//   LONG_CYCLES    hold time in cycles from PRESS to LONG
//   REPEAT_CYCLES  period in cycles between REPEAT events
//
// Ports:
//   sys_clk       in   clock, rising edge
//   sys_rst_n     in   asynchronous active-low reset
//   key_value     in   debounced key level, 0 = pressed (asynchronous)
//   evt_valid     out  an event is held in the output register
//   evt_code      out  event code, 0 when not valid
//   evt_ready     in   consumer accepts the held event on this edge
//   evt_overflow  out  sticky: at least one event was dropped
//   ovf_clr       in   synchronous clear of evt_overflow (set wins)
//   key_held      out  1 while the decoder is in a pressed state
// -----------------------------------------------------------------------------
module key_event_decoder #(
   parameter logic [31:0] LONG_CYCLES   = 32'd50000000,
   parameter logic [31:0] REPEAT_CYCLES = 32'd10000000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       key_value,
   output logic       evt_valid,
   output logic [2:0] evt_code,
   input  logic       evt_ready,
   output logic       evt_overflow,
   input  logic       ovf_clr,
   output logic       key_held
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHORT = 2'd1,
      ST_LONG  = 2'd2
   } state_t;

   localparam logic [2:0] EV_NONE          = 3'd0;
   localparam logic [2:0] EV_PRESS         = 3'd1;
   localparam logic [2:0] EV_SHORT_RELEASE = 3'd2;
   localparam logic [2:0] EV_LONG          = 3'd3;
   localparam logic [2:0] EV_LONG_RELEASE  = 3'd5;
`ifdef KEY_EVENT_REPEAT_EN
   localparam logic [2:0] EV_REPEAT        = 3'd4;
`endif

   // Counters stop at all-ones instead of wrapping back to zero.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [1:0]  sync_q;
   logic        key_lvl;
   state_t      state_q, state_d;
   logic [31:0] hold_cnt_q, hold_cnt_d;
   logic [2:0]  evt_gen;
   logic        evt_valid_q, evt_valid_d;
   logic [2:0]  evt_code_q, evt_code_d;
   logic        ovf_q, ovf_d;
`ifdef KEY_EVENT_REPEAT_EN
   logic [31:0] rep_cnt_q, rep_cnt_d;
`else
   // Repeat period has no effect in this build; keeps the parameter referenced.
   if (REPEAT_CYCLES == 32'd0) begin : g_repeat_unused
   end
`endif

   // Two-flop synchronizer; resets to the released level.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], key_value};
      end
   end

   assign key_lvl = sync_q[1];

   // Next state and event generation. Release is tested first in every
   // pressed state so it always wins over a LONG/REPEAT due on the same cycle.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
`ifdef KEY_EVENT_REPEAT_EN
      rep_cnt_d  = rep_cnt_q;
`endif
      evt_gen    = EV_NONE;

      unique case (state_q)
         ST_IDLE: begin
            if (!key_lvl) begin
               state_d    = ST_SHORT;
               hold_cnt_d = 32'd0;
               evt_gen    = EV_PRESS;
            end
         end
         ST_SHORT: begin
            if (key_lvl) begin
               state_d = ST_IDLE;
               evt_gen = EV_SHORT_RELEASE;
            end else if (hold_cnt_q == LONG_CYCLES - 32'd1) begin
               state_d   = ST_LONG;
`ifdef KEY_EVENT_REPEAT_EN
               rep_cnt_d = 32'd0;
`endif
               evt_gen   = EV_LONG;
            end else begin
               hold_cnt_d = sat_inc(hold_cnt_q);
            end
         end
         ST_LONG: begin
            if (key_lvl) begin
               state_d = ST_IDLE;
               evt_gen = EV_LONG_RELEASE;
            end
`ifdef KEY_EVENT_REPEAT_EN
            else if (rep_cnt_q == REPEAT_CYCLES - 32'd1) begin
               rep_cnt_d = 32'd0;
               evt_gen   = EV_REPEAT;
            end else begin
               rep_cnt_d = sat_inc(rep_cnt_q);
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output register: load when empty or being consumed on this edge;
   // otherwise the new event is lost and overflow is flagged.
   always_comb begin
      evt_valid_d = evt_valid_q;
      evt_code_d  = evt_code_q;
      ovf_d       = ovf_clr ? 1'b0 : ovf_q;

      if (evt_gen != EV_NONE) begin
         if (!evt_valid_q || evt_ready) begin
            evt_valid_d = 1'b1;
            evt_code_d  = evt_gen;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (evt_valid_q && evt_ready) begin
         evt_valid_d = 1'b0;
         evt_code_d  = EV_NONE;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_IDLE;
         hold_cnt_q  <= 32'd0;
`ifdef KEY_EVENT_REPEAT_EN
         rep_cnt_q   <= 32'd0;
`endif
         evt_valid_q <= 1'b0;
         evt_code_q  <= EV_NONE;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
`ifdef KEY_EVENT_REPEAT_EN
         rep_cnt_q   <= rep_cnt_d;
`endif
         evt_valid_q <= evt_valid_d;
         evt_code_q  <= evt_code_d;
         ovf_q       <= ovf_d;
      end
   end

   assign evt_valid    = evt_valid_q;
   assign evt_code     = evt_code_q;
   assign evt_overflow = ovf_q;
   assign key_held     = (state_q != ST_IDLE);

endmodule
